extract_sequencer: RTL and testbench

EXTRACT_SEQUENCER -- requirements
Module: extract_sequencer

---
 rtl/extract_sequencer_pkg.sv | 28 ++
 rtl/extract_sequencer_field.sv | 45 ++++
 rtl/extract_sequencer.sv | 179 +++++++++++++++++
 tb/tb_extract_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/extract_sequencer_pkg.sv
// Shared types for the header extract sequencer: FSM states and offset-table entries.
package extract_sequencer_pkg;

  // Sequencer states: accept a header, issue one slot per cycle, drain the
  // extractor pipeline, then present the result vector.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } seq_state_t;

  // Widest byte offset an entry can hold; module offsets are zero-extended
  // into this field, so OFFSET_WIDTH must not exceed it.
  localparam int OFFSET_MAX_WIDTH = 16;

  // One offset-table entry: a valid flag plus the byte offset into the header.
  typedef struct packed {
    logic                        valid;
    logic [OFFSET_MAX_WIDTH-1:0] offset;
  } offset_entry_t;

  // True when the stored offset addresses a byte inside the header window.
  function automatic logic entry_in_range(input offset_entry_t e, input int candi_num);
    return e.offset < OFFSET_MAX_WIDTH'(candi_num);
  endfunction

endpackage

// File: rtl/extract_sequencer_field.sv
// Shared byte extractor: selects one EXTRACT_WIDTH field from the header
// window at a given offset, optionally registering the result.
module Extract_Field #(
  parameter int CANDI_NUM      = 128,
  parameter int OFFSET_WIDTH   = 7,
  parameter int EXTRACT_WIDTH  = 8,
  parameter int INSERT_ONE_CLK = 1
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic [CANDI_NUM-1:0][EXTRACT_WIDTH-1:0] i_data,
  input  logic [OFFSET_WIDTH:0]                   i_offset,
  output logic [EXTRACT_WIDTH-1:0]                o_field
);

  logic [EXTRACT_WIDTH-1:0] field_c;

  // Select the addressed byte; an invalid or out-of-window offset yields zero.
  always_comb begin
    field_c = '0;
    if (i_offset[OFFSET_WIDTH]) begin
      for (int k = 0; k < CANDI_NUM; k++) begin
        if (int'(i_offset[OFFSET_WIDTH-1:0]) == k) begin
          field_c = i_data[k];
        end
      end
    end
  end

  generate
    if (INSERT_ONE_CLK != 0) begin : g_reg
      // Register the selected byte so the mux tree gets a full cycle.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          o_field <= '0;
        end else begin
          o_field <= field_c;
        end
      end
    end else begin : g_comb
      assign o_field = field_c;
    end
  endgenerate

endmodule

// File: rtl/extract_sequencer.sv
// Header extract sequencer: walks a per-profile offset table one slot per
// cycle through a single shared extractor and presents the collected fields.
module extract_sequencer
  import extract_sequencer_pkg::*;
#(
  parameter  int CANDI_NUM     = 128,
  parameter  int OFFSET_WIDTH  = 7,
  parameter  int EXTRACT_WIDTH = 8,
  parameter  int FIELD_NUM     = 8,
  parameter  int PROFILE_NUM   = 4,
  localparam int PROFILE_WIDTH = (PROFILE_NUM > 1) ? $clog2(PROFILE_NUM) : 1,
  localparam int IDX_WIDTH     = (FIELD_NUM > 1) ? $clog2(FIELD_NUM) : 1
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic                                    i_hdr_valid,
  output logic                                    o_hdr_ready,
  input  logic [CANDI_NUM-1:0][EXTRACT_WIDTH-1:0] i_hdr_data,
  input  logic [PROFILE_WIDTH-1:0]                i_hdr_profile,
  input  logic                                    i_cfg_wr,
  input  logic [PROFILE_WIDTH-1:0]                i_cfg_profile,
  input  logic [IDX_WIDTH-1:0]                    i_cfg_idx,
  input  logic [OFFSET_WIDTH:0]                   i_cfg_offset,
  output logic                                    o_fields_valid,
  input  logic                                    i_fields_ready,
  output logic [FIELD_NUM-1:0][EXTRACT_WIDTH-1:0] o_fields,
  output logic [FIELD_NUM-1:0]                    o_fields_mask,
  output logic [31:0]                             o_hdr_cnt
);

  seq_state_t state_q, state_d;

  offset_entry_t cfg_table [PROFILE_NUM][FIELD_NUM];
  offset_entry_t cur_entry;

  logic [CANDI_NUM-1:0][EXTRACT_WIDTH-1:0] hdr_data_q;
  logic [PROFILE_WIDTH-1:0]                profile_q;
  logic [IDX_WIDTH-1:0]                    idx_q;
  logic [IDX_WIDTH-1:0]                    slot_q;
  logic                                    capture_q;
  logic [FIELD_NUM-1:0][EXTRACT_WIDTH-1:0] fields_q;
  logic [FIELD_NUM-1:0]                    mask_q;
  logic [31:0]                             hdr_cnt_q;

  logic                     hdr_ready;
  logic                     hdr_accept;
  logic                     issue_en;
  logic                     out_accept;
  logic [OFFSET_WIDTH:0]    ext_offset;
  logic [EXTRACT_WIDTH-1:0] ext_field;

  assign hdr_ready = (state_q == ST_IDLE) && !i_rst;

  // The slot being issued this cycle; a table write in the same cycle is not
  // yet visible here, so the issued slot sees the old entry.
  assign cur_entry  = cfg_table[profile_q][idx_q];
  assign ext_offset = {cur_entry.valid && entry_in_range(cur_entry, CANDI_NUM),
                       cur_entry.offset[OFFSET_WIDTH-1:0]};

  Extract_Field #(
    .CANDI_NUM      (CANDI_NUM),
    .OFFSET_WIDTH   (OFFSET_WIDTH),
    .EXTRACT_WIDTH  (EXTRACT_WIDTH),
    .INSERT_ONE_CLK (1)
  ) u_extract (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_data   (hdr_data_q),
    .i_offset (ext_offset),
    .o_field  (ext_field)
  );

  // Next-state logic and the per-cycle control strobes of the sequencer.
  always_comb begin
    state_d    = state_q;
    hdr_accept = 1'b0;
    issue_en   = 1'b0;
    out_accept = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_hdr_valid && hdr_ready) begin
          hdr_accept = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue_en = 1'b1;
        if (idx_q == IDX_WIDTH'(FIELD_NUM - 1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (i_fields_ready) begin
          out_accept = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register; reset abandons any header in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Offset table: cleared to all-invalid on reset, writable in any state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int p = 0; p < PROFILE_NUM; p++) begin
        for (int f = 0; f < FIELD_NUM; f++) begin
          cfg_table[p][f] <= '0;
        end
      end
    end else if (i_cfg_wr) begin
      cfg_table[i_cfg_profile][i_cfg_idx] <= '{
        valid:  i_cfg_offset[OFFSET_WIDTH],
        offset: OFFSET_MAX_WIDTH'(i_cfg_offset[OFFSET_WIDTH-1:0])
      };
    end
  end

  // Header window capture; only a real handshake in IDLE updates it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hdr_data_q <= '0;
    end else if (hdr_accept) begin
      hdr_data_q <= i_hdr_data;
    end
  end

  // Slot walk, result collection one cycle behind the issue, and delivery count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      profile_q <= '0;
      idx_q     <= '0;
      slot_q    <= '0;
      capture_q <= 1'b0;
      fields_q  <= '0;
      mask_q    <= '0;
      hdr_cnt_q <= '0;
    end else begin
      capture_q <= issue_en;
      slot_q    <= idx_q;
      if (hdr_accept) begin
        profile_q <= i_hdr_profile;
        idx_q     <= '0;
        fields_q  <= '0;
        mask_q    <= '0;
      end
      if (issue_en) begin
        idx_q         <= idx_q + IDX_WIDTH'(1);
        mask_q[idx_q] <= cur_entry.valid;
      end
      if (capture_q) begin
        fields_q[slot_q] <= ext_field;
      end
      if (out_accept) begin
        hdr_cnt_q <= hdr_cnt_q + 32'd1;
      end
    end
  end

  assign o_hdr_ready    = hdr_ready;
  assign o_fields_valid = (state_q == ST_OUT) && !i_rst;
  assign o_fields       = i_rst ? '0 : fields_q;
  assign o_fields_mask  = i_rst ? '0 : mask_q;
  assign o_hdr_cnt      = i_rst ? '0 : hdr_cnt_q;

endmodule

// File: tb/tb_extract_sequencer.sv
// Directed testbench for extract_sequencer at default parameters.
module tb_extract_sequencer;

  localparam int CANDI_NUM     = 128;
  localparam int OFFSET_WIDTH  = 7;
  localparam int EXTRACT_WIDTH = 8;
  localparam int FIELD_NUM     = 8;
  localparam int PROFILE_NUM   = 4;

  logic                                    i_clk = 1'b0;
  logic                                    i_rst;
  logic                                    i_hdr_valid;
  logic                                    o_hdr_ready;
  logic [CANDI_NUM-1:0][EXTRACT_WIDTH-1:0] i_hdr_data;
  logic [1:0]                              i_hdr_profile;
  logic                                    i_cfg_wr;
  logic [1:0]                              i_cfg_profile;
  logic [2:0]                              i_cfg_idx;
  logic [OFFSET_WIDTH:0]                   i_cfg_offset;
  logic                                    o_fields_valid;
  logic                                    i_fields_ready;
  logic [FIELD_NUM-1:0][EXTRACT_WIDTH-1:0] o_fields;
  logic [FIELD_NUM-1:0]                    o_fields_mask;
  logic [31:0]                             o_hdr_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [FIELD_NUM-1:0][EXTRACT_WIDTH-1:0] exp_fields;

  extract_sequencer #(
    .CANDI_NUM     (CANDI_NUM),
    .OFFSET_WIDTH  (OFFSET_WIDTH),
    .EXTRACT_WIDTH (EXTRACT_WIDTH),
    .FIELD_NUM     (FIELD_NUM),
    .PROFILE_NUM   (PROFILE_NUM)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_hdr_valid    (i_hdr_valid),
    .o_hdr_ready    (o_hdr_ready),
    .i_hdr_data     (i_hdr_data),
    .i_hdr_profile  (i_hdr_profile),
    .i_cfg_wr       (i_cfg_wr),
    .i_cfg_profile  (i_cfg_profile),
    .i_cfg_idx      (i_cfg_idx),
    .i_cfg_offset   (i_cfg_offset),
    .o_fields_valid (o_fields_valid),
    .i_fields_ready (i_fields_ready),
    .o_fields       (o_fields),
    .o_fields_mask  (o_fields_mask),
    .o_hdr_cnt      (o_hdr_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] prof, input logic [2:0] idx, input logic [7:0] off);
    i_cfg_wr      = 1'b1;
    i_cfg_profile = prof;
    i_cfg_idx     = idx;
    i_cfg_offset  = off;
    next_cycle();
    i_cfg_wr      = 1'b0;
  endtask

  // mode 0: byte k = k; mode 1: k ^ 0xA5; mode 2: k + 100
  task automatic fill_header(input int mode);
    for (int k = 0; k < CANDI_NUM; k++) begin
      case (mode)
        0:       i_hdr_data[k] = 8'(k);
        1:       i_hdr_data[k] = 8'(k) ^ 8'hA5;
        default: i_hdr_data[k] = 8'(k + 100);
      endcase
    end
  endtask

  // Offer one header for a single cycle; on return the DUT is in cycle 1.
  task automatic offer_header(input logic [1:0] prof, input int mode);
    fill_header(mode);
    i_hdr_profile = prof;
    i_hdr_valid   = 1'b1;
    next_cycle();
    i_hdr_valid   = 1'b0;
  endtask

  // Wait for o_fields_valid, counting cycles from the handshake (cycle 0).
  task automatic wait_fields(input int start, output int cyc);
    cyc = start;
    while (o_fields_valid !== 1'b1 && cyc < 60) begin
      next_cycle();
      cyc++;
    end
  endtask

  task automatic accept_fields();
    i_fields_ready = 1'b1;
    next_cycle();
    i_fields_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_hdr_valid = 1'b0; i_hdr_profile = '0; i_hdr_data = '0;
    i_cfg_wr = 1'b0; i_cfg_profile = '0; i_cfg_idx = '0; i_cfg_offset = '0;
    i_fields_ready = 1'b0;
    next_cycle();
    next_cycle();
    tests_run++;
    if (o_hdr_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_ready: got %b, expected 0", o_hdr_ready); end
    tests_run++;
    if (o_fields_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_valid: got %b, expected 0", o_fields_valid); end
    tests_run++;
    if (o_fields !== '0) begin tests_failed++; $display("[TB] FAIL rst_fields: got %h, expected 0", o_fields); end
    tests_run++;
    if (o_fields_mask !== 8'h00) begin tests_failed++; $display("[TB] FAIL rst_mask: got %h, expected 00", o_fields_mask); end
    tests_run++;
    if (o_hdr_cnt !== 32'd0) begin tests_failed++; $display("[TB] FAIL rst_cnt: got %0d, expected 0", o_hdr_cnt); end
    i_rst = 1'b0;
    #1;
    tests_run++;
    if (o_hdr_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_release_ready: got %b, expected 1", o_hdr_ready); end
  endtask

  task automatic test_full_profile();
    int lat;
    for (int i = 0; i < FIELD_NUM; i++) cfg_write(2'd1, 3'(i), {1'b1, 7'(12 + i)});
    tests_run++;
    if (o_hdr_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_ready: got %b, expected 1", o_hdr_ready); end
    offer_header(2'd1, 0);
    wait_fields(1, lat);
    for (int i = 0; i < FIELD_NUM; i++) exp_fields[i] = 8'(12 + i);
    tests_run++;
    if (lat != 10) begin tests_failed++; $display("[TB] FAIL full_latency: got %0d, expected 10", lat); end
    tests_run++;
    if (o_fields !== exp_fields) begin tests_failed++; $display("[TB] FAIL full_fields: got %h, expected %h", o_fields, exp_fields); end
    tests_run++;
    if (o_fields_mask !== 8'hFF) begin tests_failed++; $display("[TB] FAIL full_mask: got %h, expected ff", o_fields_mask); end
    accept_fields();
    tests_run++;
    if (o_hdr_cnt !== 32'd1) begin tests_failed++; $display("[TB] FAIL full_cnt: got %0d, expected 1", o_hdr_cnt); end
    tests_run++;
    if (o_fields_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_valid_drop: got %b, expected 0", o_fields_valid); end
  endtask

  task automatic test_sparse_profile();
    int lat;
    cfg_write(2'd2, 3'd0, 8'h80);
    cfg_write(2'd2, 3'd5, 8'hFF);
    cfg_write(2'd2, 3'd1, 8'h03);
    offer_header(2'd2, 1);
    wait_fields(1, lat);
    exp_fields    = '0;
    exp_fields[0] = 8'hA5;
    exp_fields[5] = 8'hDA;
    tests_run++;
    if (lat != 10) begin tests_failed++; $display("[TB] FAIL sparse_latency: got %0d, expected 10", lat); end
    tests_run++;
    if (o_fields !== exp_fields) begin tests_failed++; $display("[TB] FAIL sparse_fields: got %h, expected %h", o_fields, exp_fields); end
    tests_run++;
    if (o_fields_mask !== 8'h21) begin tests_failed++; $display("[TB] FAIL sparse_mask: got %h, expected 21", o_fields_mask); end
    accept_fields();
    tests_run++;
    if (o_hdr_cnt !== 32'd2) begin tests_failed++; $display("[TB] FAIL sparse_cnt: got %0d, expected 2", o_hdr_cnt); end
  endtask

  task automatic test_backpressure();
    int lat;
    offer_header(2'd1, 0);
    wait_fields(1, lat);
    for (int i = 0; i < FIELD_NUM; i++) exp_fields[i] = 8'(12 + i);
    fill_header(2);
    i_hdr_profile  = 2'd1;
    i_hdr_valid    = 1'b1;
    i_fields_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if (o_fields_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_valid c%0d: got %b, expected 1", c, o_fields_valid); end
      tests_run++;
      if (o_fields !== exp_fields) begin tests_failed++; $display("[TB] FAIL hold_fields c%0d: got %h, expected %h", c, o_fields, exp_fields); end
      tests_run++;
      if (o_fields_mask !== 8'hFF) begin tests_failed++; $display("[TB] FAIL hold_mask c%0d: got %h, expected ff", c, o_fields_mask); end
      tests_run++;
      if (o_hdr_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_ready c%0d: got %b, expected 0", c, o_hdr_ready); end
      next_cycle();
    end
    accept_fields();
    tests_run++;
    if (o_hdr_cnt !== 32'd3) begin tests_failed++; $display("[TB] FAIL hold_cnt: got %0d, expected 3", o_hdr_cnt); end
    tests_run++;
    if (o_hdr_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_release_ready: got %b, expected 1", o_hdr_ready); end
    next_cycle();
    i_hdr_valid = 1'b0;
    wait_fields(1, lat);
    for (int i = 0; i < FIELD_NUM; i++) exp_fields[i] = 8'(112 + i);
    tests_run++;
    if (lat != 10) begin tests_failed++; $display("[TB] FAIL second_latency: got %0d, expected 10", lat); end
    tests_run++;
    if (o_fields !== exp_fields) begin tests_failed++; $display("[TB] FAIL second_fields: got %h, expected %h", o_fields, exp_fields); end
    accept_fields();
    tests_run++;
    if (o_hdr_cnt !== 32'd4) begin tests_failed++; $display("[TB] FAIL second_cnt: got %0d, expected 4", o_hdr_cnt); end
  endtask

  task automatic test_reset_mid_issue();
    int lat;
    int seen_valid;
    offer_header(2'd1, 0);
    next_cycle();
    next_cycle();
    next_cycle();
    i_rst = 1'b1;
    #1;
    tests_run++;
    if (o_hdr_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_ready: got %b, expected 0", o_hdr_ready); end
    next_cycle();
    i_rst = 1'b0;
    #1;
    tests_run++;
    if (o_hdr_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrst_ready_after: got %b, expected 1", o_hdr_ready); end
    tests_run++;
    if (o_hdr_cnt !== 32'd0) begin tests_failed++; $display("[TB] FAIL midrst_cnt: got %0d, expected 0", o_hdr_cnt); end
    seen_valid = 0;
    for (int c = 0; c < 15; c++) begin
      if (o_fields_valid === 1'b1) seen_valid++;
      next_cycle();
    end
    tests_run++;
    if (seen_valid != 0) begin tests_failed++; $display("[TB] FAIL midrst_no_output: got %0d valid cycles, expected 0", seen_valid); end
    offer_header(2'd1, 0);
    wait_fields(1, lat);
    tests_run++;
    if (lat != 10) begin tests_failed++; $display("[TB] FAIL midrst_latency: got %0d, expected 10", lat); end
    tests_run++;
    if (o_fields !== '0) begin tests_failed++; $display("[TB] FAIL midrst_fields: got %h, expected 0", o_fields); end
    tests_run++;
    if (o_fields_mask !== 8'h00) begin tests_failed++; $display("[TB] FAIL midrst_mask: got %h, expected 00", o_fields_mask); end
    accept_fields();
    tests_run++;
    if (o_hdr_cnt !== 32'd1) begin tests_failed++; $display("[TB] FAIL midrst_cnt_after: got %0d, expected 1", o_hdr_cnt); end
  endtask

  task automatic test_rewrite_during_issue();
    int lat;
    for (int i = 0; i < FIELD_NUM; i++) cfg_write(2'd1, 3'(i), {1'b1, 7'(12 + i)});
    offer_header(2'd1, 0);
    next_cycle();
    next_cycle();
    cfg_write(2'd1, 3'd7, {1'b1, 7'd40});
    next_cycle();
    cfg_write(2'd1, 3'd0, {1'b1, 7'd50});
    wait_fields(6, lat);
    for (int i = 0; i < FIELD_NUM; i++) exp_fields[i] = 8'(12 + i);
    exp_fields[7] = 8'd40;
    tests_run++;
    if (lat != 10) begin tests_failed++; $display("[TB] FAIL rewrite_latency: got %0d, expected 10", lat); end
    tests_run++;
    if (o_fields !== exp_fields) begin tests_failed++; $display("[TB] FAIL rewrite_fields: got %h, expected %h", o_fields, exp_fields); end
    tests_run++;
    if (o_fields_mask !== 8'hFF) begin tests_failed++; $display("[TB] FAIL rewrite_mask: got %h, expected ff", o_fields_mask); end
    accept_fields();
    tests_run++;
    if (o_hdr_cnt !== 32'd2) begin tests_failed++; $display("[TB] FAIL rewrite_cnt: got %0d, expected 2", o_hdr_cnt); end
  endtask

  task automatic test_back_to_back();
    int hs_count;
    int last_hs;
    for (int i = 0; i < FIELD_NUM; i++) exp_fields[i] = 8'(12 + i);
    exp_fields[0] = 8'd50;
    exp_fields[7] = 8'd40;
    fill_header(0);
    i_hdr_profile  = 2'd1;
    i_hdr_valid    = 1'b1;
    i_fields_ready = 1'b1;
    hs_count = 0;
    last_hs  = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (o_hdr_ready === 1'b1) begin
        if (hs_count > 0) begin
          tests_run++;
          if (cyc - last_hs != 11) begin tests_failed++; $display("[TB] FAIL b2b_spacing: got %0d, expected 11", cyc - last_hs); end
        end
        last_hs = cyc;
        hs_count++;
      end
      if (cyc % 11 == 10) begin
        tests_run++;
        if (o_fields_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_valid cyc%0d: got %b, expected 1", cyc, o_fields_valid); end
        tests_run++;
        if (o_fields !== exp_fields) begin tests_failed++; $display("[TB] FAIL b2b_fields cyc%0d: got %h, expected %h", cyc, o_fields, exp_fields); end
      end
      next_cycle();
    end
    i_hdr_valid = 1'b0;
    tests_run++;
    if (hs_count != 4) begin tests_failed++; $display("[TB] FAIL b2b_handshakes: got %0d, expected 4", hs_count); end
    for (int c = 0; c < 15; c++) next_cycle();
    i_fields_ready = 1'b0;
    tests_run++;
    if (o_hdr_cnt !== 32'd6) begin tests_failed++; $display("[TB] FAIL b2b_cnt: got %0d, expected 6", o_hdr_cnt); end
    tests_run++;
    if (o_hdr_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_idle_ready: got %b, expected 1", o_hdr_ready); end
  endtask

  initial begin
    test_reset();
    test_full_profile();
    test_sparse_profile();
    test_backpressure();
    test_reset_mid_issue();
    test_rewrite_during_issue();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

endmodule
